draw_board_sequencer: RTL
=========================

DRAW_BOARD_SEQUENCER -- requirements
Module: draw_board_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports are listed below, one per line, as name, direction, width, meaning.
REQ-002 clk, input, 1: single clock; every register SHALL update on its rising edge.
REQ-003 reset, input, 1: synchronous, active-high reset.
REQ-004 start, input, 1: request one redraw; sampled on each rising edge.
REQ-005 full_redraw, input, 1: when 1, the redraw includes the white board fill; sampled together with start.
REQ-006 mem_data, input, 6: board-cell contents from synchronous RAM; valid one cycle after mem_addr is presented.
REQ-007 mem_addr, output, 6: board-cell read address; [5:3] is y and [2:0] is x.
REQ-008 draw_value, output, 6: drawing opcode to the datapath.
REQ-009 write, output, 1: datapath pixel-write enable.
REQ-010 update_x_y, output, 1: datapath cell-advance strobe.
REQ-011 clear_counters, output, 1: zeroes the datapath counter, long_counter and x_y_pos.
REQ-012 busy, output, 1: high whenever the state is not IDLE.
REQ-013 done, output, 1: one-cycle pulse at the end of a redraw.

Function
REQ-014 The FSM states SHALL be IDLE, CLEAR, FILL, IND, FETCH, LATCH, CELL, NEXT and DONE.
REQ-015 In IDLE, start=1 SHALL latch full_redraw into fill_q and move to CLEAR.
REQ-016 CLEAR SHALL last 1 cycle, with clear_counters=1, write=0, cell index=0 and pixel count=0. The next state SHALL be FILL if fill_q=1, otherwise IND.
REQ-017 FILL SHALL last exactly 32768 cycles, with write=1 and draw_value=6'b011000 throughout; a 15-bit count wrapping to 0 moves the FSM to IND.
REQ-018 IND SHALL last exactly 256 cycles, with write=1 and draw_value=6'b011100; an 8-bit count wrapping to 0 moves the FSM to FETCH.
REQ-019 FETCH SHALL last 1 cycle, with mem_addr=cell index and write=0.
REQ-020 LATCH SHALL last 1 cycle: mem_data is captured into cell_q on its closing edge, and write=0.
REQ-021 CELL SHALL last exactly 256 cycles, with write=1 and draw_value=cell_q throughout.
REQ-022 NEXT SHALL last 1 cycle, with update_x_y=1, write=0, and the cell index incremented modulo 64.
REQ-023 After NEXT, if the old cell index was 63 the FSM SHALL go to DONE; otherwise it SHALL go to FETCH.
REQ-024 DONE SHALL last 1 cycle with done=1. It SHALL then go to CLEAR if pending=1, clearing pending and loading fill_q from pend_fill; otherwise it SHALL go to IDLE.
REQ-025 write and update_x_y SHALL never be 1 in the same cycle. clear_counters SHALL never be 1 together with either of them.
REQ-026 draw_value SHALL be 6'b000000 outside FILL, IND and CELL. mem_addr SHALL always equal the cell index.
REQ-027 A start while busy=1 (including the DONE cycle) SHALL set pending=1 and store full_redraw into pend_fill; the last such request wins. Requests are never dropped and never queued deeper than one.
REQ-028 Latency from the edge that samples start in IDLE to the done cycle SHALL be 49601 cycles with full_redraw=1 and 16833 cycles with full_redraw=0. Each breaks down as CLEAR 1 + FILL 32768 + IND 256 + 64×259 per cell.
REQ-029 The cell index SHALL wrap from 63 to 0, and x_y_pos in the datapath SHALL likewise return to 0 after the final update_x_y.
REQ-030 start held high continuously SHALL produce back-to-back redraws, going from DONE directly to CLEAR with no IDLE cycle in between.

Reset
REQ-031 When reset=1 at an edge, the state SHALL go to IDLE and pending, fill_q, pend_fill, cell index, counts and cell_q SHALL all be cleared. reset SHALL take priority over start.
REQ-032 The reset value of every output SHALL be 0: write, update_x_y, clear_counters, busy, done, mem_addr and draw_value.
REQ-033 Reset asserted mid-FILL or mid-CELL SHALL drop write to 0 on the next cycle. Any pending request SHALL be discarded and done SHALL not pulse.

Verification
REQ-034 Scenario 1: reset, then start=1 and full_redraw=1 for 1 cycle -> clear_counters high for 1 cycle; 32768 write cycles with draw_value=0x18; 256 with draw_value=0x1C; done 49601 cycles after start; exactly 64 update_x_y pulses.
REQ-035 Scenario 2: start with full_redraw=0 and RAM preloaded with cell k = k -> no 0x18 writes; cell k draws 256 cycles of draw_value=k; mem_addr for each cell precedes its data by 1 cycle; done at cycle 16833.
REQ-036 Scenario 3: a second start with full_redraw=1 during the CELL of cell 10 -> after done, the FSM enters CLEAR on the next cycle and the second redraw includes FILL; 2 done pulses in total.
REQ-037 Scenario 4: reset asserted 5000 cycles into FILL with a pending request -> the next cycle has busy=0, write=0 and all outputs 0; no done pulse; state IDLE until a new start.
REQ-038 Scenario 5: start held high for 120000 cycles with full_redraw=0 -> DONE is followed directly by CLEAR; done pulses spaced 16834 cycles apart; write, update_x_y and clear_counters never overlap (assertion).

Source files
------------

// File: rtl/draw_board_sequencer.sv
// Redraw sequencer for the board display: optional white fill, indicator strip,
// then 64 cells fetched from board RAM and drawn for 256 pixel cycles each.
module draw_board_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       full_redraw,
  input  logic [5:0] mem_data,
  output logic [5:0] mem_addr,
  output logic [5:0] draw_value,
  output logic       write,
  output logic       update_x_y,
  output logic       clear_counters,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, FILL, IND, FETCH, LATCH, CELL, NEXT, DONE
  } state_t;

  localparam logic [5:0] FILL_COLOR = 6'b011000;
  localparam logic [5:0] IND_COLOR  = 6'b011100;

  state_t      state_reg, state_next;
  logic        fill_reg, fill_next;
  logic        pend_reg, pend_next;
  logic        pend_fill_reg, pend_fill_next;
  logic [5:0]  cell_idx_reg, cell_idx_next;
  logic [5:0]  cell_reg, cell_next;
  logic [14:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      fill_reg      <= 1'b0;
      pend_reg      <= 1'b0;
      pend_fill_reg <= 1'b0;
      cell_idx_reg  <= 6'd0;
      cell_reg      <= 6'd0;
      count_reg     <= 15'd0;
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      pend_reg      <= pend_next;
      pend_fill_reg <= pend_fill_next;
      cell_idx_reg  <= cell_idx_next;
      cell_reg      <= cell_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    fill_next      = fill_reg;
    pend_next      = pend_reg;
    pend_fill_next = pend_fill_reg;
    cell_idx_next  = cell_idx_reg;
    cell_next      = cell_reg;
    count_next     = count_reg;
    draw_value     = 6'd0;
    write          = 1'b0;
    update_x_y     = 1'b0;
    clear_counters = 1'b0;
    done           = 1'b0;
    mem_addr       = cell_idx_reg;
    busy           = (state_reg != IDLE);

    // A request arriving mid-redraw parks in the single pending slot; newest wins.
    if (start && state_reg != IDLE) begin
      pend_next      = 1'b1;
      pend_fill_next = full_redraw;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          fill_next  = full_redraw;
          pend_next  = 1'b0;
        end else if (pend_reg) begin
          // Request that landed on the DONE cycle with nothing else pending
          state_next = CLEAR;
          fill_next  = pend_fill_reg;
          pend_next  = 1'b0;
        end
      end
      CLEAR: begin
        clear_counters = 1'b1;
        count_next     = 15'd0;
        cell_idx_next  = 6'd0;
        state_next     = fill_reg ? FILL : IND;
      end
      FILL: begin
        write      = 1'b1;
        draw_value = FILL_COLOR;
        count_next = count_reg + 15'd1;
        if (count_reg == 15'h7fff) state_next = IND;
      end
      IND: begin
        write      = 1'b1;
        draw_value = IND_COLOR;
        if (count_reg[7:0] == 8'hff) begin
          count_next = 15'd0;
          state_next = FETCH;
        end else begin
          count_next = count_reg + 15'd1;
        end
      end
      FETCH: state_next = LATCH;
      LATCH: begin
        cell_next  = mem_data;
        state_next = CELL;
      end
      CELL: begin
        write      = 1'b1;
        draw_value = cell_reg;
        if (count_reg[7:0] == 8'hff) begin
          count_next = 15'd0;
          state_next = NEXT;
        end else begin
          count_next = count_reg + 15'd1;
        end
      end
      NEXT: begin
        update_x_y    = 1'b1;
        cell_idx_next = cell_idx_reg + 6'd1;
        state_next    = (cell_idx_reg == 6'd63) ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (pend_reg) begin
          // A start on this very cycle becomes the next pending request
          state_next = CLEAR;
          fill_next  = pend_fill_reg;
          pend_next  = start;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
